bp_update_sched: RTL and testbench

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_update_sched.sv | 71 +++++++
 tb/tb_bp_update_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bp_update_sched.sv
// bp_update_sched: queues branch-predictor updates from two exe pipes and sweeps the table clear after reset/flush
module bp_update_sched #(
  parameter int SET_NUM = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int INDEX_BITS = $clog2(SET_NUM)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  input  logic [31:0]           req0_pc,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [31:0]           req1_pc,
  output logic                  req1_ready,
  input  logic                  flush_req,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [31:0]           wr_pc,
  output logic [INDEX_BITS-1:0] wr_index,
  output logic                  clr_en,
  output logic [INDEX_BITS-1:0] clr_index,
  output logic                  init_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t                state_q;
  logic [INDEX_BITS-1:0] clr_idx_q;
  logic [CW-1:0]         count_q, count_d, free;
  logic [PW-1:0]         head_q, tail_q;
  logic [31:0]           mem_q [FIFO_DEPTH];
  logic                  run, acc0, acc1, pop;
  // Outputs are gated by resetn so they hold their reset values for the whole reset window.
  always_comb begin
    run        = resetn & (state_q == RUN);
    free       = CW'(FIFO_DEPTH) - count_q;
    req0_ready = run & !flush_req & (free != '0);
    req1_ready = run & !flush_req & ((free >= CW'(2)) | ((free == CW'(1)) & !req0_valid));
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    wr_valid   = run & (count_q != '0);
    wr_pc      = mem_q[head_q];
    wr_index   = wr_pc[4 +: INDEX_BITS];
    pop        = wr_valid & wr_ready;
    count_d    = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    init_busy  = !resetn | (state_q == INIT);
    clr_en     = init_busy;
    clr_index  = (resetn && state_q == INIT) ? clr_idx_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!resetn || flush_req) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else if (state_q == INIT) begin
      clr_idx_q <= clr_idx_q + INDEX_BITS'(1);
      if (clr_idx_q == INDEX_BITS'(SET_NUM - 1)) state_q <= RUN;
    end else begin
      count_q <= count_d;
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(acc0) + PW'(acc1);
    end
  end
  // req0 is older, so it takes the tail slot and req1 the one behind it.
  always_ff @(posedge clk) begin
    if (acc0) mem_q[tail_q] <= req0_pc;
    if (acc1) mem_q[tail_q + PW'(acc0)] <= req1_pc;
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed checks of the clear sweep, dual enqueue, backpressure and flush, then a scoreboarded random run
module tb_bp_update_sched;
  logic clk = 0, resetn = 0;
  logic req0_valid = 0, req1_valid = 0, flush_req = 0, wr_ready = 0;
  logic [31:0] req0_pc = 0, req1_pc = 0;
  logic req0_ready, req1_ready, wr_valid, clr_en, init_busy;
  logic [31:0] wr_pc;
  logic [1:0] wr_index, clr_index;
  int total = 0, bad = 0;

  bp_update_sched #(.SET_NUM(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_ready(req1_ready),
    .flush_req(flush_req), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_pc(wr_pc), .wr_index(wr_index), .clr_en(clr_en),
    .clr_index(clr_index), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk({tag, "_busy"}, 32'(init_busy), 1);
      chk({tag, "_clr_en"}, 32'(clr_en), 1);
      chk({tag, "_clr_idx"}, 32'(clr_index), i);
      chk({tag, "_wv"}, 32'(wr_valid), 0);
      cyc();
    end
    #1;
    chk({tag, "_done_busy"}, 32'(init_busy), 0);
    chk({tag, "_done_clr_en"}, 32'(clr_en), 0);
  endtask

  initial begin
    int mc;
    logic [31:0] q[$];
    logic v0, v1, er0, er1;
    logic [31:0] p0, p1;
    resetn = 0;
    cyc(); cyc();
    #1;
    chk("rst_r0", 32'(req0_ready), 0);
    chk("rst_r1", 32'(req1_ready), 0);
    chk("rst_wv", 32'(wr_valid), 0);
    chk("rst_clr_en", 32'(clr_en), 1);
    chk("rst_clr_idx", 32'(clr_index), 0);
    chk("rst_busy", 32'(init_busy), 1);
    cyc();
    resetn = 1;
    sweep("init");
    chk("init_r0", 32'(req0_ready), 1);
    chk("init_clr_idx_run", 32'(clr_index), 0);
    // dual request ordering
    wr_ready = 1;
    req0_valid = 1; req0_pc = 32'h10;
    req1_valid = 1; req1_pc = 32'h24;
    #1;
    chk("dual_r0", 32'(req0_ready), 1);
    chk("dual_r1", 32'(req1_ready), 1);
    chk("dual_wv0", 32'(wr_valid), 0);
    cyc();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("dual_wv1", 32'(wr_valid), 1);
    chk("dual_pc1", wr_pc, 32'h10);
    chk("dual_idx1", 32'(wr_index), 1);
    cyc(); #1;
    chk("dual_wv2", 32'(wr_valid), 1);
    chk("dual_pc2", wr_pc, 32'h24);
    chk("dual_idx2", 32'(wr_index), 2);
    cyc(); #1;
    chk("dual_empty", 32'(wr_valid), 0);
    // fill with backpressure
    wr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_pc = 32'h100 + 32'(i) * 32'h10;
      #1;
      chk("fill_r0", 32'(req0_ready), 1);
      cyc();
    end
    req0_valid = 1; req0_pc = 32'h130;
    req1_valid = 1; req1_pc = 32'h999;
    #1;
    chk("free1_r0", 32'(req0_ready), 1);
    chk("free1_r1", 32'(req1_ready), 0);
    cyc();
    wr_ready = 1;
    #1;
    chk("full_r0", 32'(req0_ready), 0);
    chk("full_r1", 32'(req1_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_wv", 32'(wr_valid), 1);
      chk("drain_pc", wr_pc, 32'h100 + 32'(i) * 32'h10);
      cyc();
      req0_valid = 0; req1_valid = 0;
      #1;
    end
    chk("drain_empty", 32'(wr_valid), 0);
    // flush with three queued entries
    wr_ready = 0;
    req0_valid = 1; req0_pc = 32'h40;
    req1_valid = 1; req1_pc = 32'h50;
    cyc();
    req1_valid = 0; req0_pc = 32'h60;
    cyc();
    req0_valid = 0;
    flush_req = 1;
    #1;
    chk("flush_wv_pre", 32'(wr_valid), 1);
    chk("flush_r0", 32'(req0_ready), 0);
    cyc();
    flush_req = 0;
    wr_ready = 1;
    sweep("flush");
    chk("flush_discard", 32'(wr_valid), 0);
    cyc(); #1;
    chk("flush_discard2", 32'(wr_valid), 0);
    // flush again mid-sweep
    flush_req = 1;
    cyc();
    flush_req = 0;
    cyc(); cyc();
    #1;
    chk("restart_at2", 32'(clr_index), 2);
    flush_req = 1;
    cyc();
    flush_req = 0;
    sweep("restart");
    // random traffic against a queue model
    mc = 0;
    for (int n = 0; n < 10000; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      p0 = $urandom; p1 = $urandom;
      req0_valid = v0; req0_pc = p0;
      req1_valid = v1; req1_pc = p1;
      wr_ready = ($urandom_range(0, 3) != 0);
      #1;
      er0 = (4 - mc) >= 1;
      er1 = ((4 - mc) >= 2) || (((4 - mc) == 1) && !v0);
      if (req0_ready !== er0 || req1_ready !== er1 || wr_valid !== (mc != 0))
        chk("rnd_hs", {29'd0, req0_ready, req1_ready, wr_valid}, {29'd0, er0, er1, mc != 0});
      if (mc != 0 && wr_pc !== q[0]) chk("rnd_pc", wr_pc, q[0]);
      if (mc != 0 && wr_ready) void'(q.pop_front());
      if (v0 && er0) q.push_back(p0);
      if (v1 && er1) q.push_back(p1);
      mc = q.size();
      cyc();
    end
    req0_valid = 0; req1_valid = 0; wr_ready = 1;
    #1;
    chk("rnd_final_wv", 32'(wr_valid), 32'(mc != 0));
    if (mc != 0) chk("rnd_final_pc", wr_pc, q[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
